// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accepts one 32-bit ALU request over a valid/ready handshake. It registers the
//   operands, evaluates the op, and holds result/overflow/err until the consumer
//   accepts them. Single-cycle ops go through EXEC. Multiplies go through a
//   32-step shift-add MUL state, then a FIX state that applies the sign and
//   computes overflow.
//
//   Build option: define ALU_OP_SEQ_FAST_MUL_EN to route ops 2/7 through a
//   combinational 64-bit multiply in EXEC. In that build the MUL/FIX hardware
//   is not built.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     in_valid/in_ready            request handshake (ready only in IDLE)
//     in_op, in_a, in_b            opcode and operands
//     out_valid/out_ready          response handshake (valid only in DONE)
//     out_result, out_overflow     result and overflow flag
//     out_err                      illegal opcode flag
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_overflow,
    output logic                  out_err
);
    localparam int W = DATA_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_ADDS = 5'd0,  OP_SUBS = 5'd1,  OP_MULS = 5'd2;
    localparam logic [OP_WIDTH-1:0] OP_MAXS = 5'd3,  OP_MINS = 5'd4,  OP_ADDU = 5'd5;
    localparam logic [OP_WIDTH-1:0] OP_SUBU = 5'd6,  OP_MULU = 5'd7,  OP_MAXU = 5'd8;
    localparam logic [OP_WIDTH-1:0] OP_MINU = 5'd9,  OP_AND  = 5'd10, OP_OR   = 5'd11;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 5'd12, OP_NOT  = 5'd13, OP_REV  = 5'd14;
    localparam logic [OP_WIDTH-1:0] OP_LTS  = 5'd15, OP_GES  = 5'd16;

    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_FIX, S_DONE} state_t;

    state_t state, state_n;

    logic [OP_WIDTH-1:0] op_q;
    logic [W-1:0]        a_q, b_q;

    // Single-cycle evaluation; returns {err, ovf, result}.
    function automatic logic [W+1:0] alu_eval(input logic [OP_WIDTH-1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r, nb;
        logic [W:0]   s;
        logic         ovf, err;
`ifdef ALU_OP_SEQ_FAST_MUL_EN
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0]        pu;
`endif
        r   = '0;
        nb  = '0;
        s   = '0;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADDS: begin
                r   = a + b;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUBS: begin
                nb  = ~b + ONE_W;
                r   = a + nb;
                ovf = (a[W-1] == nb[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_ADDU: begin
                s   = {1'b0, a} + {1'b0, b};
                r   = s[W-1:0];
                ovf = s[W];
            end
            OP_SUBU: begin
                r   = a - b;
                ovf = (a < b);
            end
`ifdef ALU_OP_SEQ_FAST_MUL_EN
            OP_MULS: begin
                ps  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                r   = ps[W-1:0];
                ovf = (ps[2*W-1:W-1] != {(W+1){ps[W-1]}});
            end
            OP_MULU: begin
                pu  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r   = pu[W-1:0];
                ovf = (pu[2*W-1:W] != '0);
            end
`endif
            OP_MAXS: r = ($signed(a) < $signed(b)) ? b : a;
            OP_MINS: r = ($signed(a) >= $signed(b)) ? b : a;
            OP_MAXU: r = (a < b) ? b : a;
            OP_MINU: r = (b < a) ? b : a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_REV:  for (int i = 0; i < W; i++) r[i] = a[W-1-i];
            OP_LTS:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_GES:  r = {{(W-1){1'b0}}, ($signed(a) >= $signed(b))};
            default: err = 1'b1;
        endcase
        return {err, ovf, r};
    endfunction

`ifndef ALU_OP_SEQ_FAST_MUL_EN
    logic [5:0]     cnt;
    logic [2*W-1:0] mcand, acc, prod;
    logic [W-1:0]   mplier, abs_a, abs_b;
    logic           msign, msigned, prod_ovf, in_is_signed;

    assign in_is_signed = (in_op == OP_MULS);
    assign abs_a = (in_is_signed && in_a[W-1]) ? (~in_a + ONE_W) : in_a;
    assign abs_b = (in_is_signed && in_b[W-1]) ? (~in_b + ONE_W) : in_b;
    assign prod  = msign ? (~acc + (2*W)'(1)) : acc;
    assign prod_ovf = msigned ? (prod[2*W-1:W-1] != {(W+1){prod[W-1]}})
                              : (prod[2*W-1:W] != '0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_OP_SEQ_FAST_MUL_EN
                    state_n = S_EXEC;
`else
                    state_n = (in_op == OP_MULS || in_op == OP_MULU) ? S_MUL : S_EXEC;
`endif
                end
            end
            S_EXEC: state_n = S_DONE;
`ifndef ALU_OP_SEQ_FAST_MUL_EN
            S_MUL:  if (cnt == 6'd31) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
`endif
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Operand capture and multiplier datapath; reloaded on every accept, so no reset
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
`ifndef ALU_OP_SEQ_FAST_MUL_EN
            mcand   <= {{W{1'b0}}, abs_a};
            mplier  <= abs_b;
            acc     <= '0;
            msigned <= in_is_signed;
            msign   <= in_is_signed & (in_a[W-1] ^ in_b[W-1]);
`endif
        end
`ifndef ALU_OP_SEQ_FAST_MUL_EN
        else if (state == S_MUL) begin
            // One multiplier bit per step, LSB first
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
`endif
    end

    // Result registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_err      <= 1'b0;
`ifndef ALU_OP_SEQ_FAST_MUL_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                S_EXEC: {out_err, out_overflow, out_result} <= alu_eval(op_q, a_q, b_q);
`ifndef ALU_OP_SEQ_FAST_MUL_EN
                S_MUL:  cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
                S_FIX: begin
                    out_result   <= prod[W-1:0];
                    out_overflow <= prod_ovf;
                    out_err      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_err;

`ifdef ALU_OP_SEQ_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_op_sequencer #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one request and push its expected response; returns just after the accept edge.
    task automatic send(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic ovf,
                        input logic err, input int lat);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        sb.push_back('{tag, res, ovf, err, lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " busy"}, 32'(in_ready), 32'd0);
    endtask

    // Wait for the response, pop the scoreboard and compare; optionally complete the handshake.
    task automatic recv(input bit complete);
        exp_t e;
        int   lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        chk({e.tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({e.tag, " latency"},   32'(lat),       32'(e.lat));
        chk({e.tag, " result"},    out_result,     e.res);
        chk({e.tag, " ovf"},       32'(out_overflow), 32'(e.ovf));
        chk({e.tag, " err"},       32'(out_err),      32'(e.err));
        if (complete) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " in_ready"},  32'(in_ready),     32'd1);
        chk({tag, " out_valid"}, 32'(out_valid),    32'd0);
        chk({tag, " result"},    out_result,        32'd0);
        chk({tag, " ovf"},       32'(out_overflow), 32'd0);
        chk({tag, " err"},       32'(out_err),      32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle_zero("reset");

        // Signed add overflow
        send("adds", 5'd0, 32'h00000003, 32'h7FFFFFFD, 32'h80000000, 1'b1, 1'b0, 2); recv(1);

        // Multiplies
        send("muls", 5'd2, 32'h00000003, 32'h7FFFFFFD, 32'h7FFFFFF7, 1'b1, 1'b0, MUL_LAT); recv(1);
        send("mulu", 5'd7, 32'h00000003, 32'h7FFFFFFD, 32'h7FFFFFF7, 1'b1, 1'b0, MUL_LAT); recv(1);
        send("muls_neg", 5'd2, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 1'b0, MUL_LAT); recv(1);
        send("muls_min1", 5'd2, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 1'b0, MUL_LAT); recv(1);
        send("muls_minmin", 5'd2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, MUL_LAT); recv(1);
        send("muls_m1m1", 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, MUL_LAT); recv(1);
        send("mulu_max", 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, MUL_LAT); recv(1);

        // Assorted single-cycle ops
        send("subu", 5'd6,  32'h00000003, 32'h7FFFFFFD, 32'h80000006, 1'b1, 1'b0, 2); recv(1);
        send("rev",  5'd14, 32'h00000003, 32'h7FFFFFFD, 32'hC0000000, 1'b0, 1'b0, 2); recv(1);
        send("lts",  5'd15, 32'h00000003, 32'h7FFFFFFD, 32'h00000001, 1'b0, 1'b0, 2); recv(1);
        send("ges",  5'd16, 32'h00000003, 32'h7FFFFFFD, 32'h00000000, 1'b0, 1'b0, 2); recv(1);
        send("maxs", 5'd3,  32'h00000003, 32'h7FFFFFFD, 32'h7FFFFFFD, 1'b0, 1'b0, 2); recv(1);
        send("subs", 5'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 2); recv(1);
        send("addu", 5'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2); recv(1);
        send("mins", 5'd4,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 2); recv(1);
        send("minu", 5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 2); recv(1);
        send("maxu", 5'd8,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 2); recv(1);
        send("and",  5'd10, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 2); recv(1);
        send("or",   5'd11, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 2); recv(1);
        send("xor",  5'd12, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 2); recv(1);
        send("not",  5'd13, 32'hFF00FF00, 32'h0FF00FF0, 32'h00FF00FF, 1'b0, 1'b0, 2); recv(1);

        // Illegal opcode, then a legal op clears err
        send("illegal", 5'd20, 32'h00000003, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 2); recv(1);
        send("after_illegal", 5'd0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 2); recv(1);

        // Back-pressure: result held while out_ready is low, new requests ignored
        out_ready = 1'b0;
        send("hold", 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 2); recv(0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = 5'd0; in_a = 32'd1; in_b = 32'd1;
            @(posedge clk); #1;
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold in_ready",  32'(in_ready),  32'd0);
            chk("hold result",    out_result,     32'h80000000);
            chk("hold ovf",       32'(out_overflow), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid", 32'(out_valid), 32'd0);
        chk("release in_ready",  32'(in_ready),  32'd1);

        // Reset in the middle of a multiply aborts it
        send("abort", 5'd2, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, MUL_LAT);
        void'(sb.pop_back());
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_zero("abort");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("abort no response", 32'(seen), 32'd0);
        send("post_abort", 5'd0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 2); recv(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
